// File: rtl/tick_gen_pkg.sv
// ----------------------------------------------------------------------------
// tick_gen_pkg
// Shared constants for the tick/random generator:
//   - default counter and LFSR widths
//   - default LFSR feedback taps (out[7] ^ out[3] for the 8-bit source)
//   - default per-channel reset periods (ch0 in the LSBs)
//   - max_len_taps(): standard XNOR feedback tap masks for widths 4..32,
//     for instances that want a maximal-length sequence
// No ports (package).
// ----------------------------------------------------------------------------
package tick_gen_pkg;

  localparam int          CNT_W_DEF   = 24;
  localparam int          LFSR_W_DEF  = 8;
  localparam logic [7:0]  TAPS_DEF    = 8'h88;

  localparam logic [23:0] PER0_RST    = 24'd1000000;
  localparam logic [23:0] PER1_RST    = 24'd12500000;
  localparam logic [47:0] PER_RST_DEF = {PER1_RST, PER0_RST};

  // Bit i set means out[i] feeds the XNOR. Widths outside 4..32 fall back to
  // the two top bits, which is valid but not maximal length.
  function automatic logic [31:0] max_len_taps(input int w);
    logic [31:0] taps;
    case (w)
      4:       taps = 32'h0000000C;
      5:       taps = 32'h00000014;
      6:       taps = 32'h00000030;
      7:       taps = 32'h00000060;
      8:       taps = 32'h000000B8;
      9:       taps = 32'h00000110;
      10:      taps = 32'h00000240;
      11:      taps = 32'h00000500;
      12:      taps = 32'h00000829;
      13:      taps = 32'h0000100D;
      14:      taps = 32'h00002015;
      15:      taps = 32'h00006000;
      16:      taps = 32'h0000D008;
      17:      taps = 32'h00012000;
      18:      taps = 32'h00020400;
      19:      taps = 32'h00040023;
      20:      taps = 32'h00090000;
      21:      taps = 32'h00140000;
      22:      taps = 32'h00300000;
      23:      taps = 32'h00420000;
      24:      taps = 32'h00E10000;
      25:      taps = 32'h01200000;
      26:      taps = 32'h02000023;
      27:      taps = 32'h04000013;
      28:      taps = 32'h09000000;
      29:      taps = 32'h14000000;
      30:      taps = 32'h20000029;
      31:      taps = 32'h48000000;
      32:      taps = 32'h80200003;
      default: taps = 32'h00000003 << ((w > 2 ? w : 2) - 2);
    endcase
    return taps;
  endfunction

endpackage

// File: rtl/lfsr_core.sv
// ----------------------------------------------------------------------------
// lfsr_core
// XNOR Fibonacci LFSR with synchronous load and lockup recovery.
//   i_clk    : clock
//   i_rst_n  : asynchronous reset, active low (state -> 0)
//   i_adv    : advance one step this cycle
//   i_ld     : load i_ld_val this cycle (wins over i_adv)
//   i_ld_val : load value; all-ones is replaced by 0
//   o_q      : current LFSR state
// ----------------------------------------------------------------------------
module lfsr_core #(
  parameter int           W    = 8,
  parameter logic [W-1:0] TAPS = W'(8'h88)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_adv,
  input  logic         i_ld,
  input  logic [W-1:0] i_ld_val,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;
  logic [W-1:0] w_step;

  // All-ones is the XNOR lockup state; stepping out of it goes to zero so the
  // register can never stay stuck there.
  assign w_step = (&r_q) ? '0 : {r_q[W-2:0], ~^(r_q & TAPS)};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_ld) begin
      r_q <= (&i_ld_val) ? '0 : i_ld_val;
    end else if (i_adv) begin
      r_q <= w_step;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/tick_rand_gen.sv
// ----------------------------------------------------------------------------
// tick_rand_gen
// NCH independent programmable clock-enable tick channels plus an LFSR that
// steps on every tick of channel RAND_CH.
// Optional feature macro: TICK_SEED_EN (adds seed_ld / seed load ports).
//   internal_clk : system clock
//   reset_n      : asynchronous reset, active low
//   enable       : global run; 0 freezes counters and LFSR, forces tick/rand_vld 0
//   per_wr       : one-cycle strobe, load per_data into channel per_sel
//   per_sel      : channel select for per_wr (out-of-range values ignored)
//   per_data     : new period in cycles, 0 disables the channel
//   seed_ld      : (TICK_SEED_EN) load seed into LFSR, works with enable=0
//   seed         : (TICK_SEED_EN) seed value, all-ones loads 0
//   tick         : registered one-cycle tick per channel
//   rand_num     : current LFSR state
//   rand_vld     : pulses in the cycle rand_num shows a new value
// ----------------------------------------------------------------------------
module tick_rand_gen
  import tick_gen_pkg::*;
#(
  parameter int                   NCH     = 2,
  parameter int                   CNT_W   = CNT_W_DEF,
  parameter int                   LFSR_W  = LFSR_W_DEF,
  parameter logic [LFSR_W-1:0]    TAPS    = TAPS_DEF,
  parameter int                   RAND_CH = 1,
  parameter logic [NCH*CNT_W-1:0] PER_RST = PER_RST_DEF,
  localparam int                  SEL_W   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              internal_clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              per_wr,
  input  logic [SEL_W-1:0]  per_sel,
  input  logic [CNT_W-1:0]  per_data,
`ifdef TICK_SEED_EN
  input  logic              seed_ld,
  input  logic [LFSR_W-1:0] seed,
`endif
  output logic [NCH-1:0]    tick,
  output logic [LFSR_W-1:0] rand_num,
  output logic              rand_vld
);

  logic [NCH-1:0]    w_term;
  logic              w_ld;
  logic [LFSR_W-1:0] w_seed;
  logic              r_vld;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_per;
    logic             r_tick;
    logic             w_sel;
    logic             w_run;
    logic             w_shrink;

    assign w_sel     = per_wr && (int'(per_sel) == c);
    assign w_run     = enable && (r_per != '0);
    assign w_term[c] = w_run && (r_cnt == r_per);
    // A new period at or below the current count would otherwise make the
    // counter run all the way round 2^CNT_W before matching again.
    assign w_shrink  = w_sel && (per_data <= r_cnt);

    // The terminal compare uses the old period, so a write landing on it still
    // ticks and the new period takes effect from the restarted count.
    always_ff @(posedge internal_clk or negedge reset_n) begin
      if (!reset_n) begin
        r_cnt  <= CNT_W'(1);
        r_per  <= PER_RST[c*CNT_W +: CNT_W];
        r_tick <= 1'b0;
      end else begin
        r_tick <= w_term[c];
        if (w_sel) begin
          r_per <= per_data;
        end
        if (w_term[c] || w_shrink || (r_per == '0)) begin
          r_cnt <= CNT_W'(1);
        end else if (w_run) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
    end

    assign tick[c] = r_tick;
  end

`ifdef TICK_SEED_EN
  assign w_ld   = seed_ld;
  assign w_seed = seed;
`else
  assign w_ld   = 1'b0;
  assign w_seed = '0;
`endif

  // The LFSR steps on the same edge that registers tick[RAND_CH], so the new
  // value and rand_vld appear together with that tick.
  lfsr_core #(
    .W    (LFSR_W),
    .TAPS (TAPS)
  ) u_lfsr (
    .i_clk    (internal_clk),
    .i_rst_n  (reset_n),
    .i_adv    (w_term[RAND_CH]),
    .i_ld     (w_ld),
    .i_ld_val (w_seed),
    .o_q      (rand_num)
  );

  always_ff @(posedge internal_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= 1'b0;
    end else begin
      r_vld <= w_term[RAND_CH] || w_ld;
    end
  end

  assign rand_vld = r_vld;

endmodule
